// File: rtl/dec2bcd_pkg.sv
// Shared types, constants and the key-line decoder for the decimal-to-BCD encoder.
package dec2bcd_pkg;

  typedef enum logic {IDLE, HELD} state_t;

  localparam logic [9:0] KEY_IDLE  = 10'h3FF;
  localparam logic [3:0] BCD_EMPTY = 4'hF;

  // Returns {multi, digit}: multi is set when two or more lines are low,
  // digit is the lowest-numbered low line (BCD_EMPTY when none are low).
  function automatic logic [4:0] onehot_low_to_bcd(input logic [9:0] lines);
    logic [3:0] digit;
    logic [3:0] lows;
    digit = BCD_EMPTY;
    lows  = '0;
    for (int i = 9; i >= 0; i--) begin
      if (!lines[i]) begin
        digit = 4'(i);
        lows  = lows + 4'd1;
      end
    end
    return {(lows > 4'd1), digit};
  endfunction

endpackage

// File: rtl/dec2bcd_encoder_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into a full FIFO
// succeeds only when a pop frees a slot on the same edge.
module bcd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/dec2bcd_encoder.sv
// Synchronizes and debounces ten active-low key lines, encodes single-key
// presses to BCD and queues them for a valid/ready consumer.
module dec2bcd_encoder
  import dec2bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              Reset_n,
  input  logic                              Preset,
  input  logic [9:0]                        key_n,
  output logic [3:0]                        out_bcd,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              err,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES+1);
  localparam int STABLE_AT = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_AT);

  logic [9:0]       sync1_reg;
  logic [9:0]       sync2_reg;
  logic [9:0]       prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  state_t           state_reg;
  logic             err_reg;
  logic             overflow_reg;

  logic             stable;
  logic [4:0]       decoded;
  logic             push;
  logic             pop;
  logic             flush;
  logic             fifo_empty;
  logic             fifo_full;
  logic [3:0]       fifo_head;

  // The stable strobe fires on the edge where the counter steps to DEBOUNCE_CYCLES-1.
  assign stable  = (sync2_reg == prev_reg) && (cnt_reg == CNT_STABLE);
  assign decoded = onehot_low_to_bcd(sync2_reg);
  assign flush   = !Reset_n || Preset;
  assign push    = !flush && (state_reg == IDLE) && stable &&
                   (sync2_reg != KEY_IDLE) && !decoded[4];
  assign pop     = !flush && out_ready;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      sync1_reg <= KEY_IDLE;
      sync2_reg <= KEY_IDLE;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n || Preset) begin
      prev_reg     <= Reset_n ? sync2_reg : KEY_IDLE;
      cnt_reg      <= '0;
      state_reg    <= HELD;
      err_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      prev_reg <= sync2_reg;
      err_reg  <= 1'b0;
      if (sync2_reg != prev_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (stable && (sync2_reg != KEY_IDLE)) begin
            err_reg   <= decoded[4];
            state_reg <= HELD;
          end
        end
        HELD: begin
          if (stable && (sync2_reg == KEY_IDLE)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= HELD;
      endcase

      if (push && fifo_full && !(pop && !fifo_empty)) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  bcd_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .flush     (flush),
    .push      (push),
    .push_data (decoded[3:0]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_bcd   = fifo_empty ? BCD_EMPTY : fifo_head;
  assign err       = err_reg;
  assign overflow  = overflow_reg;

endmodule
